// File: rtl/memref_rd_arbiter.sv
// rtl/memref_rd_arbiter.sv - round-robin arbiter with port lock sharing one memref read port
module memref_rd_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_rd_en,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_grant,
  output logic [NREQ-1:0]          req_rd_valid,
  output logic [DATA_W-1:0]        req_rd_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd_en,
  input  logic [DATA_W-1:0]        mem_rd_data,
  input  logic                     clr_cnt,
  output logic [15:0]              conflict_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   start;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   gnt_idx;
  logic            locked;
  logic            hold_lock;
  logic            gnt_any;
  logic            stall;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rd_valid_q;
  logic [15:0]     cnt_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // A releasing owner still yields a normal round-robin pass starting just after itself.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    hold_lock = locked && req_lock[owner];
    start     = locked ? wrap_inc(owner) : ptr;
    cand      = start;
    if (rst_n) begin
      if (hold_lock) begin
        if (req_rd_en[owner]) begin
          grant[owner] = 1'b1;
          gnt_idx      = owner;
          gnt_any      = 1'b1;
        end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (!gnt_any && req_rd_en[cand]) begin
            grant[cand] = 1'b1;
            gnt_idx     = cand;
            gnt_any     = 1'b1;
          end
          cand = wrap_inc(cand);
        end
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    if (gnt_any) mem_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  end

  assign stall        = |(req_rd_en & ~grant);
  assign req_grant    = grant;
  assign mem_rd_en    = gnt_any;
  assign req_rd_valid = rd_valid_q;
  assign req_rd_data  = mem_rd_data;
  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      locked     <= 1'b0;
      rd_valid_q <= '0;
      cnt_q      <= '0;
    end else begin
      rd_valid_q <= grant;
      if (clr_cnt) cnt_q <= '0;
      else if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      // ptr stays parked while the owner holds the port
      if (!hold_lock) begin
        if (gnt_any) begin
          ptr    <= wrap_inc(gnt_idx);
          locked <= req_lock[gnt_idx];
          owner  <= gnt_idx;
        end else begin
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memref_rd_arbiter.sv
// tb/tb_memref_rd_arbiter.sv - directed vector bench for memref_rd_arbiter
module tb_memref_rd_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_rd_en;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_grant;
  logic [NREQ-1:0]   req_rd_valid;
  logic [DW-1:0]     req_rd_data;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd_en;
  logic [DW-1:0]     mem_rd_data;
  logic              clr_cnt;
  logic [15:0]       conflict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memref_rd_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd_en(req_rd_en), .req_addr(req_addr),
    .req_lock(req_lock), .req_grant(req_grant), .req_rd_valid(req_rd_valid),
    .req_rd_data(req_rd_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .clr_cnt(clr_cnt), .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    en;
    logic [1:0]    lock;
    logic          clr;
    logic [AW-1:0] a1;
    logic [DW-1:0] md;
    logic [1:0]    g;
    logic [AW-1:0] ma;
    logic [1:0]    v;
    logic [15:0]   cnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // round robin
    vecs[0]  = '{2'b11, 2'b00, 1'b0, 6'd9,  32'hA0A0_0001, 2'b01, 6'd5,  2'b00, 16'd0};
    vecs[1]  = '{2'b11, 2'b00, 1'b0, 6'd9,  32'hA0A0_0002, 2'b10, 6'd9,  2'b01, 16'd1};
    vecs[2]  = '{2'b11, 2'b00, 1'b0, 6'd9,  32'hA0A0_0003, 2'b01, 6'd5,  2'b10, 16'd2};
    vecs[3]  = '{2'b11, 2'b00, 1'b0, 6'd9,  32'hA0A0_0004, 2'b10, 6'd9,  2'b01, 16'd3};
    vecs[4]  = '{2'b00, 2'b00, 1'b0, 6'd9,  32'hA0A0_0005, 2'b00, 6'd0,  2'b10, 16'd4};
    // single requester
    vecs[5]  = '{2'b10, 2'b00, 1'b0, 6'd12, 32'hB0B0_0001, 2'b10, 6'd12, 2'b00, 16'd4};
    vecs[6]  = '{2'b10, 2'b00, 1'b0, 6'd12, 32'hB0B0_0002, 2'b10, 6'd12, 2'b10, 16'd4};
    vecs[7]  = '{2'b10, 2'b00, 1'b0, 6'd12, 32'hB0B0_0003, 2'b10, 6'd12, 2'b10, 16'd4};
    vecs[8]  = '{2'b00, 2'b00, 1'b0, 6'd12, 32'hB0B0_0004, 2'b00, 6'd0,  2'b10, 16'd4};
    // lock, bubble, release
    vecs[9]  = '{2'b01, 2'b01, 1'b0, 6'd12, 32'hC0C0_0001, 2'b01, 6'd5,  2'b00, 16'd4};
    vecs[10] = '{2'b10, 2'b01, 1'b0, 6'd12, 32'hC0C0_0002, 2'b00, 6'd0,  2'b01, 16'd4};
    vecs[11] = '{2'b11, 2'b01, 1'b0, 6'd12, 32'hC0C0_0003, 2'b01, 6'd5,  2'b00, 16'd5};
    vecs[12] = '{2'b10, 2'b00, 1'b0, 6'd12, 32'hC0C0_0004, 2'b10, 6'd12, 2'b01, 16'd6};
    vecs[13] = '{2'b00, 2'b00, 1'b0, 6'd12, 32'hC0C0_0005, 2'b00, 6'd0,  2'b10, 16'd6};
    // clear, then non-granted lock has no effect
    vecs[14] = '{2'b00, 2'b00, 1'b1, 6'd9,  32'hD0D0_0001, 2'b00, 6'd0,  2'b00, 16'd6};
    vecs[15] = '{2'b00, 2'b00, 1'b0, 6'd9,  32'hD0D0_0002, 2'b00, 6'd0,  2'b00, 16'd0};
    vecs[16] = '{2'b11, 2'b10, 1'b0, 6'd9,  32'hD0D0_0003, 2'b01, 6'd5,  2'b00, 16'd0};
    vecs[17] = '{2'b11, 2'b00, 1'b0, 6'd9,  32'hD0D0_0004, 2'b10, 6'd9,  2'b01, 16'd1};
    vecs[18] = '{2'b00, 2'b00, 1'b0, 6'd9,  32'hD0D0_0005, 2'b00, 6'd0,  2'b10, 16'd2};

    rst_n = 1'b0;
    req_rd_en = '0;
    req_lock = '0;
    clr_cnt = 1'b0;
    req_addr = {6'd9, 6'd5};
    mem_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_grant", 32'(req_grant), 32'h0);
    check("reset_valid", 32'(req_rd_valid), 32'h0);
    check("reset_cnt", 32'(conflict_cnt), 32'h0);
    check("reset_mem_en", 32'(mem_rd_en), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      req_rd_en   = vecs[i].en;
      req_lock    = vecs[i].lock;
      clr_cnt     = vecs[i].clr;
      req_addr    = {vecs[i].a1, 6'd5};
      mem_rd_data = vecs[i].md;
      @(negedge clk);
      check($sformatf("v%0d_grant", i), 32'(req_grant), 32'(vecs[i].g));
      check($sformatf("v%0d_mem_en", i), 32'(mem_rd_en), 32'(|vecs[i].g));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].ma));
      check($sformatf("v%0d_valid", i), 32'(req_rd_valid), 32'(vecs[i].v));
      check($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d_rd_data", i), req_rd_data, vecs[i].md);
    end
    clr_cnt = 1'b0;

    // idle: ptr is 0 after vecs, must still be 0 after 10 idle cycles
    req_addr = {6'd9, 6'd5};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_rd_en = 2'b00;
      req_lock  = 2'b00;
      @(negedge clk);
      check("idle_mem_en", 32'(mem_rd_en), 32'h0);
      check("idle_mem_addr", 32'(mem_addr), 32'h0);
    end
    @(posedge clk); #1;
    req_rd_en = 2'b11;
    @(negedge clk);
    check("idle_ptr_hold", 32'(req_grant), 32'h1);

    // saturation: lock to req0, bubble with req1 pending
    @(posedge clk); #1;
    req_rd_en = 2'b00;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    req_rd_en = 2'b01;
    req_lock = 2'b01;
    @(negedge clk);
    check("sat_lock_grant", 32'(req_grant), 32'h1);
    check("sat_start_cnt", 32'(conflict_cnt), 32'h0);
    @(posedge clk); #1;
    req_rd_en = 2'b10;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_preload", 32'(conflict_cnt), 32'hFFFE);
    check("sat_bubble_grant", 32'(req_grant), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("sat_clear", 32'(conflict_cnt), 32'h0);
    req_lock = 2'b00;
    @(negedge clk);
    check("sat_release_grant", 32'(req_grant), 32'h2);

    // async reset between grant and edge
    @(posedge clk); #1;
    req_rd_en = 2'b01;
    @(posedge clk); #1;
    req_rd_en = 2'b11;
    @(negedge clk);
    check("ar_pre_grant", 32'(req_grant), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(req_grant), 32'h0);
    check("ar_mem_en", 32'(mem_rd_en), 32'h0);
    check("ar_mem_addr", 32'(mem_addr), 32'h0);
    check("ar_valid", 32'(req_rd_valid), 32'h0);
    check("ar_cnt", 32'(conflict_cnt), 32'h0);
    @(posedge clk); #1;
    check("ar_valid_after_edge", 32'(req_rd_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first_grant", 32'(req_grant), 32'h1);
    check("ar_first_addr", 32'(mem_addr), 32'd5);
    @(posedge clk); #1;
    check("ar_first_valid", 32'(req_rd_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
